mc_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS-subset datapath: a Moore FSM that sequences fetch, decode, execute, memory and write-back over several clocks, sharing one ALU and one handshaked memory port. It is the successor to the single-cycle decoder. It adds wait-state tolerance, a retired-instruction counter and an illegal-instruction flag, and has parametrised control widths. It sits between the instruction register (IR) opcode/funct fields and the multi-cycle datapath muxes and enables.

---
 rtl/mc_ctrl_pkg.sv | 91 +++++++++
 rtl/mc_alu_dec.sv | 79 +++++++
 rtl/mc_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS-subset control unit
// and the datapath it drives (state enum, opcodes, functs, ALU/extension
// codes and mux select codes).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH,
    S_JUMP,
    S_JR
  } state_t;

  // Instruction class produced by the decoder and used for DECODE dispatch.
  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_JR,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam int ALU_OP_BITS = 5;
  localparam logic [ALU_OP_BITS-1:0] ALU_ADD  = 5'd0;
  localparam logic [ALU_OP_BITS-1:0] ALU_ADDU = 5'd1;
  localparam logic [ALU_OP_BITS-1:0] ALU_SUB  = 5'd2;
  localparam logic [ALU_OP_BITS-1:0] ALU_SUBU = 5'd3;
  localparam logic [ALU_OP_BITS-1:0] ALU_AND  = 5'd4;
  localparam logic [ALU_OP_BITS-1:0] ALU_OR   = 5'd5;
  localparam logic [ALU_OP_BITS-1:0] ALU_SLL  = 5'd6;
  localparam logic [ALU_OP_BITS-1:0] ALU_SRL  = 5'd7;
  localparam logic [ALU_OP_BITS-1:0] ALU_SLT  = 5'd8;
  localparam logic [ALU_OP_BITS-1:0] ALU_EQL  = 5'd9;
  localparam logic [ALU_OP_BITS-1:0] ALU_BNE  = 5'd10;

  localparam int EXT_BITS = 2;
  localparam logic [EXT_BITS-1:0] EXT_ZERO = 2'd0;
  localparam logic [EXT_BITS-1:0] EXT_SIGN = 2'd1;
  localparam logic [EXT_BITS-1:0] EXT_HIGH = 2'd2;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_EXT     = 2'd2;
  localparam logic [1:0] SRC_B_EXT_SH2 = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational opcode/funct decode into instruction class,
// execute-phase ALU op and immediate extension mode, plus legality.
// Optional feature macro: MC_CTRL_JAL_EN (accepts JAL and JR).
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  output instr_class_t           cls,
  output logic [ALU_OP_BITS-1:0] alu_op,
  output logic [EXT_BITS-1:0]    ext_op,
  output logic                   legal
);

  // Map the IR fields to a class and the operation used in EXEC/BRANCH.
  always_comb begin
    cls    = CLS_ILLEGAL;
    alu_op = ALU_ADD;
    ext_op = EXT_ZERO;
    case (opcode)
      OP_RTYPE: begin
        cls = CLS_R;
        case (funct)
          FN_ADDU: alu_op = ALU_ADDU;
          FN_SUBU: alu_op = ALU_SUBU;
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SLT:  alu_op = ALU_SLT;
`ifdef MC_CTRL_JAL_EN
          FN_JR:   cls = CLS_JR;
`endif
          default: cls = CLS_ILLEGAL;
        endcase
      end
      OP_ORI: begin
        cls    = CLS_I;
        alu_op = ALU_OR;
        ext_op = EXT_ZERO;
      end
      OP_SLTI: begin
        cls    = CLS_I;
        alu_op = ALU_SLT;
        ext_op = EXT_SIGN;
      end
      OP_LUI: begin
        cls    = CLS_I;
        alu_op = ALU_ADDU;
        ext_op = EXT_HIGH;
      end
      OP_LW: begin
        cls    = CLS_LOAD;
        ext_op = EXT_SIGN;
      end
      OP_SW: begin
        cls    = CLS_STORE;
        ext_op = EXT_SIGN;
      end
      OP_BEQ: begin
        cls    = CLS_BRANCH;
        alu_op = ALU_EQL;
      end
      OP_BNE: begin
        cls    = CLS_BRANCH;
        alu_op = ALU_BNE;
      end
      OP_J:   cls = CLS_JUMP;
`ifdef MC_CTRL_JAL_EN
      OP_JAL: cls = CLS_JUMP;
`endif
      default: cls = CLS_ILLEGAL;
    endcase
    legal = (cls != CLS_ILLEGAL);
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle Moore control FSM for the MIPS-subset datapath with a
// handshaked memory port, retired-instruction counter and sticky illegal flag.
// Optional feature macro: MC_CTRL_JAL_EN (adds JAL via JUMP and JR state).
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int EXT_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               i_or_d,
  output logic               ir_wr,
  output logic               pc_wr,
  output logic               pc_wr_cond,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_ctrl,
  output logic [EXT_W-1:0]   ext_op,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic               reg_wr,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_cnt
);

  state_t                 state;
  state_t                 next_state;
  instr_class_t           cls;
  logic [ALU_OP_BITS-1:0] dec_alu;
  logic [EXT_BITS-1:0]    dec_ext;
  logic                   legal;
  logic [ALU_OP_BITS-1:0] alu_op;
  logic [EXT_BITS-1:0]    ext_sel;
  logic                   req;
  logic                   retire;
  logic [CNT_W-1:0]       cnt_q;
  logic                   illegal_q;

  mc_alu_dec u_dec (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls),
    .alu_op (dec_alu),
    .ext_op (dec_ext),
    .legal  (legal)
  );

  // State register; reset restarts the machine at instruction fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  // Next-state logic: memory states wait for the handshake, DECODE dispatches.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (cls)
          CLS_R:      next_state = S_EXEC_R;
          CLS_I:      next_state = S_EXEC_I;
          CLS_LOAD:   next_state = S_MEM_ADDR;
          CLS_STORE:  next_state = S_MEM_ADDR;
          CLS_BRANCH: next_state = S_BRANCH;
          CLS_JUMP:   next_state = S_JUMP;
          CLS_JR:     next_state = S_JR;
          default:    next_state = S_FETCH;
        endcase
      end
      S_EXEC_R:   next_state = S_WB_ALU;
      S_EXEC_I:   next_state = S_WB_ALU;
      S_MEM_ADDR: next_state = (cls == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) next_state = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  // Output decode from the current state (plus handshake strobes in FETCH).
  always_comb begin
    req        = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_wr_cond = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    alu_op     = ALU_ADD;
    ext_sel    = EXT_ZERO;
    reg_dst    = DST_RT;
    wb_sel     = WB_ALUOUT;
    reg_wr     = 1'b0;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        req       = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_wr     = mem_ready & rst_n;
        pc_wr     = mem_ready & rst_n;
      end
      S_DECODE: begin
        alu_src_b = SRC_B_EXT_SH2;
        ext_sel   = EXT_SIGN;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_EXT;
        alu_op    = dec_alu;
        ext_sel   = dec_ext;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_EXT;
        ext_sel   = EXT_SIGN;
      end
      S_MEM_RD: begin
        req    = 1'b1;
        i_or_d = 1'b1;
      end
      S_MEM_WR: begin
        req    = 1'b1;
        mem_we = 1'b1;
        i_or_d = 1'b1;
        retire = mem_ready;
      end
      S_WB_ALU: begin
        reg_wr  = 1'b1;
        reg_dst = (opcode == OP_RTYPE) ? DST_RD : DST_RT;
        retire  = 1'b1;
      end
      S_WB_MEM: begin
        reg_wr = 1'b1;
        wb_sel = WB_MDR;
        retire = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        pc_wr_cond = 1'b1;
        pc_src     = PC_SRC_ALUOUT;
        alu_op     = dec_alu;
        retire     = 1'b1;
      end
      S_JUMP: begin
        pc_wr  = 1'b1;
        pc_src = PC_SRC_JUMP;
        retire = 1'b1;
`ifdef MC_CTRL_JAL_EN
        if (opcode == OP_JAL) begin
          reg_wr  = 1'b1;
          reg_dst = DST_RA;
          wb_sel  = WB_PC;
        end
`endif
      end
      S_JR: begin
        pc_wr  = 1'b1;
        pc_src = PC_SRC_RS;
        retire = 1'b1;
      end
      default: ;
    endcase
  end

  // The request is gated by reset so an in-flight access is abandoned at once.
  assign mem_req   = req & rst_n;
  assign alu_ctrl  = ALUOP_W'(alu_op);
  assign ext_op    = EXT_W'(ext_sel);
  assign illegal   = illegal_q;
  assign instr_cnt = cnt_q;

  // Retired-instruction counter and sticky illegal-instruction flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
      if ((state == S_DECODE) && !legal) illegal_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven check of mc_ctrl instruction sequencing plus
// hand-written wait-state, reset, illegal and counter-wrap sequences.
// Honours MC_CTRL_JAL_EN the same way as the design.
module tb_mc_ctrl;

  localparam int CNT_W = 32;

  localparam logic [4:0] A_ADD  = 5'd0;
  localparam logic [4:0] A_ADDU = 5'd1;
  localparam logic [4:0] A_SUB  = 5'd2;
  localparam logic [4:0] A_OR   = 5'd5;
  localparam logic [4:0] A_SLL  = 5'd6;
  localparam logic [4:0] A_SLT  = 5'd8;
  localparam logic [4:0] A_EQL  = 5'd9;
  localparam logic [4:0] A_BNE  = 5'd10;
  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_SIGN = 2'd1;
  localparam logic [1:0] X_HIGH = 2'd2;

  localparam logic [5:0] O_R    = 6'b000000;
  localparam logic [5:0] O_J    = 6'b000010;
  localparam logic [5:0] O_JAL  = 6'b000011;
  localparam logic [5:0] O_BEQ  = 6'b000100;
  localparam logic [5:0] O_BNE  = 6'b000101;
  localparam logic [5:0] O_SLTI = 6'b001010;
  localparam logic [5:0] O_ORI  = 6'b001101;
  localparam logic [5:0] O_LUI  = 6'b001111;
  localparam logic [5:0] O_LW   = 6'b100011;
  localparam logic [5:0] O_SW   = 6'b101011;
  localparam logic [5:0] O_BAD  = 6'b111111;

  localparam logic [CNT_W-1:0] CNT_ONES = '1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       opcode = '0;
  logic [5:0]       funct = '0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, i_or_d, ir_wr, pc_wr, pc_wr_cond;
  logic [1:0]       pc_src, alu_src_b, reg_dst, wb_sel;
  logic             alu_src_a, reg_wr, illegal;
  logic [4:0]       alu_ctrl;
  logic [1:0]       ext_op;
  logic [CNT_W-1:0] instr_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] opcode;
    logic [5:0] funct;
    int         cycles;
    logic [4:0] alu;
    logic [1:0] ext;
    logic       wr;
    logic [1:0] dst;
    logic [1:0] wb;
    int         cnt;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  mc_ctrl #(.ALUOP_W(5), .EXT_W(2), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .i_or_d     (i_or_d),
    .ir_wr      (ir_wr),
    .pc_wr      (pc_wr),
    .pc_wr_cond (pc_wr_cond),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .ext_op     (ext_op),
    .reg_dst    (reg_dst),
    .wb_sel     (wb_sel),
    .reg_wr     (reg_wr),
    .illegal    (illegal),
    .instr_cnt  (instr_cnt)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  function automatic void addVec(input logic [5:0] op, input logic [5:0] fn, input int cyc,
                                 input logic [4:0] alu, input logic [1:0] ext, input logic wr,
                                 input logic [1:0] dst, input logic [1:0] wb, input int cnt,
                                 input logic ill);
    vec_t v;
    v.opcode = op; v.funct = fn; v.cycles = cyc; v.alu = alu; v.ext = ext;
    v.wr = wr; v.dst = dst; v.wb = wb; v.cnt = cnt; v.ill = ill;
    vecs.push_back(v);
  endfunction

  // Run one instruction from reset with zero-wait memory and compare its trace.
  task automatic applyStimulus(input vec_t v, input int idx);
    int         cyc_seen;
    logic       wr_seen;
    logic [1:0] dst_seen, wb_seen;
    logic [4:0] alu3;
    logic [1:0] ext3;
    opcode = v.opcode;
    funct = v.funct;
    mem_ready = 1'b1;
    doReset();
    cyc_seen = -1; wr_seen = 1'b0; dst_seen = '0; wb_seen = '0; alu3 = '0; ext3 = '0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1 && mem_req && !i_or_d) begin
        cyc_seen = c - 1;
        break;
      end
      if (c == 3) begin
        alu3 = alu_ctrl;
        ext3 = ext_op;
      end
      if (reg_wr) begin
        wr_seen = 1'b1;
        dst_seen = reg_dst;
        wb_seen = wb_sel;
      end
      stepCycle();
    end
    checkOutput($sformatf("v%0d.cycles", idx), cyc_seen, v.cycles);
    checkOutput($sformatf("v%0d.alu", idx), alu3, v.alu);
    checkOutput($sformatf("v%0d.ext", idx), ext3, v.ext);
    checkOutput($sformatf("v%0d.reg_wr", idx), wr_seen, v.wr);
    checkOutput($sformatf("v%0d.reg_dst", idx), dst_seen, v.dst);
    checkOutput($sformatf("v%0d.wb_sel", idx), wb_seen, v.wb);
    checkOutput($sformatf("v%0d.cnt", idx), instr_cnt, v.cnt);
    checkOutput($sformatf("v%0d.illegal", idx), illegal, v.ill);
  endtask

  // Main test sequence.
  initial begin
    //      opcode  funct       cyc alu     ext     wr dst wb cnt ill
    addVec(O_R,    6'b100001, 4, A_ADDU, X_ZERO, 1, 1, 0, 1, 0);
    addVec(O_R,    6'b100010, 4, A_SUB,  X_ZERO, 1, 1, 0, 1, 0);
    addVec(O_R,    6'b101010, 4, A_SLT,  X_ZERO, 1, 1, 0, 1, 0);
    addVec(O_R,    6'b000000, 4, A_SLL,  X_ZERO, 1, 1, 0, 1, 0);
    addVec(O_ORI,  6'b000000, 4, A_OR,   X_ZERO, 1, 0, 0, 1, 0);
    addVec(O_SLTI, 6'b000000, 4, A_SLT,  X_SIGN, 1, 0, 0, 1, 0);
    addVec(O_LUI,  6'b000000, 4, A_ADDU, X_HIGH, 1, 0, 0, 1, 0);
    addVec(O_LW,   6'b000000, 5, A_ADD,  X_SIGN, 1, 0, 1, 1, 0);
    addVec(O_SW,   6'b000000, 4, A_ADD,  X_SIGN, 0, 0, 0, 1, 0);
    addVec(O_BEQ,  6'b000000, 3, A_EQL,  X_ZERO, 0, 0, 0, 1, 0);
    addVec(O_BNE,  6'b000000, 3, A_BNE,  X_ZERO, 0, 0, 0, 1, 0);
    addVec(O_J,    6'b000000, 3, A_ADD,  X_ZERO, 0, 0, 0, 1, 0);
    addVec(O_BAD,  6'b000000, 2, A_ADD,  X_ZERO, 0, 0, 0, 0, 1);
    addVec(O_R,    6'b111111, 2, A_ADD,  X_ZERO, 0, 0, 0, 0, 1);
`ifdef MC_CTRL_JAL_EN
    addVec(O_JAL,  6'b000000, 3, A_ADD,  X_ZERO, 1, 2, 2, 1, 0);
    addVec(O_R,    6'b001000, 3, A_ADD,  X_ZERO, 0, 0, 0, 1, 0);
`else
    addVec(O_JAL,  6'b000000, 2, A_ADD,  X_ZERO, 0, 0, 0, 0, 1);
    addVec(O_R,    6'b001000, 2, A_ADD,  X_ZERO, 0, 0, 0, 0, 1);
`endif

    // Reset state: FETCH outputs, counters cleared, strobes wait for ready.
    mem_ready = 1'b0;
    doReset();
    checkOutput("rst.mem_req", mem_req, 1);
    checkOutput("rst.i_or_d", i_or_d, 0);
    checkOutput("rst.alu_src_b", alu_src_b, 1);
    checkOutput("rst.ir_wr", ir_wr, 0);
    checkOutput("rst.cnt", instr_cnt, 0);
    checkOutput("rst.illegal", illegal, 0);
    stepCycle();
    checkOutput("fetchwait.mem_req", mem_req, 1);
    checkOutput("fetchwait.pc_wr", pc_wr, 0);
    mem_ready = 1'b1;
    #1;
    checkOutput("fetch.ir_wr", ir_wr, 1);
    checkOutput("fetch.pc_wr", pc_wr, 1);

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // LW with two wait states in MEM_RD.
    opcode = O_LW; funct = '0; mem_ready = 1'b1;
    doReset();
    stepCycle();
    checkOutput("lw.c2.alu_src_b", alu_src_b, 3);
    stepCycle();
    mem_ready = 1'b0;
    checkOutput("lw.c3.mem_req", mem_req, 0);
    for (int c = 4; c <= 6; c++) begin
      stepCycle();
      checkOutput($sformatf("lw.c%0d.mem_req", c), mem_req, 1);
      checkOutput($sformatf("lw.c%0d.i_or_d", c), i_or_d, 1);
      checkOutput($sformatf("lw.c%0d.mem_we", c), mem_we, 0);
      if (c == 6) mem_ready = 1'b1;
    end
    stepCycle();
    checkOutput("lw.c7.reg_wr", reg_wr, 1);
    checkOutput("lw.c7.wb_sel", wb_sel, 1);
    checkOutput("lw.c7.reg_dst", reg_dst, 0);
    checkOutput("lw.c7.mem_req", mem_req, 0);
    stepCycle();
    checkOutput("lw.c8.cnt", instr_cnt, 1);

    // BNE: branch state controls in cycle 3.
    opcode = O_BNE;
    doReset();
    stepCycle();
    stepCycle();
    checkOutput("bne.pc_wr_cond", pc_wr_cond, 1);
    checkOutput("bne.pc_src", pc_src, 1);
    checkOutput("bne.alu_ctrl", alu_ctrl, A_BNE);
    checkOutput("bne.alu_src_a", alu_src_a, 1);
    checkOutput("bne.alu_src_b", alu_src_b, 0);
    checkOutput("bne.pc_wr", pc_wr, 0);

    // SW: write access in cycle 4.
    opcode = O_SW;
    doReset();
    repeat (3) stepCycle();
    checkOutput("sw.mem_we", mem_we, 1);
    checkOutput("sw.mem_req", mem_req, 1);
    checkOutput("sw.i_or_d", i_or_d, 1);
    checkOutput("sw.reg_wr", reg_wr, 0);

    // Illegal opcode: flag is sticky and the counter only counts real retires.
    opcode = O_BAD;
    doReset();
    stepCycle();
    checkOutput("ill.c2.illegal", illegal, 0);
    stepCycle();
    checkOutput("ill.c3.illegal", illegal, 1);
    checkOutput("ill.c3.fetch", {mem_req, i_or_d}, 2'b10);
    checkOutput("ill.c3.cnt", instr_cnt, 0);
    opcode = O_R; funct = 6'b100001;
    repeat (4) stepCycle();
    checkOutput("ill.sticky", illegal, 1);
    checkOutput("ill.after.cnt", instr_cnt, 1);

    // Reset pulsed during a MEM_WR wait.
    opcode = O_J; mem_ready = 1'b1;
    doReset();
    repeat (3) stepCycle();
    checkOutput("rstmid.pre.cnt", instr_cnt, 1);
    opcode = O_SW;
    stepCycle();
    stepCycle();
    mem_ready = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("rstmid.wait.mem_req", mem_req, 1);
    checkOutput("rstmid.wait.mem_we", mem_we, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid.drop.mem_req", mem_req, 0);
    checkOutput("rstmid.drop.mem_we", mem_we, 0);
    checkOutput("rstmid.drop.cnt", instr_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    checkOutput("rstmid.rel.mem_req", mem_req, 1);
    checkOutput("rstmid.rel.i_or_d", i_or_d, 0);
    stepCycle();
    checkOutput("rstmid.decode.alu_src_b", alu_src_b, 3);
    checkOutput("rstmid.decode.cnt", instr_cnt, 0);

    // Counter wrap: preset to all ones, then retire one J.
    opcode = O_J; mem_ready = 1'b0;
    doReset();
    force dut.cnt_q = CNT_ONES;
    stepCycle();
    release dut.cnt_q;
    checkOutput("wrap.preset", instr_cnt, CNT_ONES);
    mem_ready = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("wrap.j.pc_wr", pc_wr, 1);
    checkOutput("wrap.j.pc_src", pc_src, 2);
    checkOutput("wrap.j.reg_wr", reg_wr, 0);
    stepCycle();
    checkOutput("wrap.cnt", instr_cnt, 0);

`ifdef MC_CTRL_JAL_EN
    // JAL links PC+4 into $31; JR takes rs as the next PC.
    opcode = O_JAL;
    doReset();
    stepCycle();
    stepCycle();
    checkOutput("jal.reg_wr", reg_wr, 1);
    checkOutput("jal.reg_dst", reg_dst, 2);
    checkOutput("jal.wb_sel", wb_sel, 2);
    checkOutput("jal.pc_src", pc_src, 2);
    opcode = O_R; funct = 6'b001000;
    doReset();
    stepCycle();
    stepCycle();
    checkOutput("jr.pc_wr", pc_wr, 1);
    checkOutput("jr.pc_src", pc_src, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
